// File: rtl/vc_out_sched.sv
// Output-side scheduler for one router input port's VC buffers: fixed-priority pick
// (highest VC wins), wormhole lock per packet, one-deep registered valid/ready output.
module vc_out_sched #(
    parameter int NumVirtChn = 2,
    parameter int FlitWidth  = 34,
    parameter int PktSzWidth = 8,
    localparam int VcWidth   = $clog2(NumVirtChn)
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic [NumVirtChn*FlitWidth-1:0]  vc_fdata_i,
    input  logic [NumVirtChn-1:0]            vc_valid_i,
    output logic [NumVirtChn-1:0]            vc_ready_o,
    output logic [FlitWidth-1:0]             fdata_o,
    output logic [VcWidth-1:0]               vc_id_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic                             lock_o,
    output logic                             err_o,
    output logic                             dbg_state
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [1:0] TYPE_HEAD = 2'b00;
    localparam logic [1:0] TYPE_TAIL = 2'b10;
    localparam logic [1:0] TYPE_RSVD = 2'b11;

    state_t                 state;
    logic [VcWidth-1:0]     locked_vc;
    logic [VcWidth-1:0]     grant_idx;
    logic                   grant_vld;
    logic                   accept;
    logic                   xfer;
    logic [FlitWidth-1:0]   grant_flit;
    logic [1:0]             grant_type;
    logic [PktSzWidth-1:0]  grant_size;

    // Valid/ready: a flit moves on any edge where valid and ready are both high; the
    // producer holds data stable while valid is high and ready is low.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state == IDLE) begin
            for (int v = 0; v < NumVirtChn; v++) begin
                if (vc_valid_i[v]) begin
                    grant_vld = 1'b1;
                    grant_idx = VcWidth'(v);
                end
            end
        end else begin
            grant_vld = vc_valid_i[locked_vc];
            grant_idx = locked_vc;
        end
    end

    assign accept     = ~valid_o | ready_i;
    assign xfer       = accept & grant_vld & arst_n;
    assign grant_flit = vc_fdata_i[int'(grant_idx) * FlitWidth +: FlitWidth];
    assign grant_type = grant_flit[FlitWidth-1 -: 2];
    assign grant_size = grant_flit[FlitWidth-3 -: PktSzWidth];
    assign vc_ready_o = xfer ? (NumVirtChn'(1) << grant_idx) : '0;
    assign dbg_state  = (state == LOCKED);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            locked_vc <= '0;
            fdata_o   <= '0;
            vc_id_o   <= '0;
            valid_o   <= 1'b0;
            lock_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (xfer) begin
                fdata_o <= grant_flit;
                vc_id_o <= grant_idx;
                valid_o <= 1'b1;
                if (state == IDLE) begin
                    if (grant_type == TYPE_HEAD) begin
                        if (grant_size != '0) begin
                            state     <= LOCKED;
                            lock_o    <= 1'b1;
                            locked_vc <= grant_idx;
                        end
                    end else begin
                        err_o <= 1'b1;
                    end
                end else begin
                    // A HEAD inside a packet re-targets the lock to the new packet.
                    if (grant_type == TYPE_HEAD) begin
                        err_o <= 1'b1;
                        if (grant_size == '0) begin
                            state  <= IDLE;
                            lock_o <= 1'b0;
                        end
                    end else if (grant_type == TYPE_TAIL) begin
                        state  <= IDLE;
                        lock_o <= 1'b0;
                    end else if (grant_type == TYPE_RSVD) begin
                        err_o <= 1'b1;
                    end
                end
            end else if (accept) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vc_out_sched.sv
// Bench for vc_out_sched: per-VC source queues, a reference arbitration model that
// predicts vc_ready_o/valid_o/lock_o/err_o, and a scoreboard of expected output flits.
module tb_vc_out_sched;

    localparam int NV = 2;
    localparam int FW = 34;
    localparam int PW = 8;
    localparam int SW = FW + 1;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic [NV*FW-1:0] vc_fdata = '0;
    logic [NV-1:0]   vc_valid = '0;
    logic [NV-1:0]   vc_ready;
    logic [FW-1:0]   fdata;
    logic            vc_id;
    logic            valid;
    logic            ready = 1'b0;
    logic            lock;
    logic            err;
    logic            dbg_state;

    always #5 clk = ~clk;

    vc_out_sched #(.NumVirtChn(NV), .FlitWidth(FW), .PktSzWidth(PW)) dut (
        .clk(clk), .arst_n(arst_n), .vc_fdata_i(vc_fdata), .vc_valid_i(vc_valid),
        .vc_ready_o(vc_ready), .fdata_o(fdata), .vc_id_o(vc_id), .valid_o(valid),
        .ready_i(ready), .lock_o(lock), .err_o(err), .dbg_state(dbg_state)
    );

    logic [FW-1:0] src_q0[$];
    logic [FW-1:0] src_q1[$];
    logic [SW-1:0] exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic rdy = 1'b1;
    logic m_valid = 1'b0, m_lock = 1'b0, m_l = 1'b0, m_err = 1'b0;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [PW-1:0] s,
                                         input logic [23:0] p);
        return {t, s, p};
    endfunction

    task automatic push_pkt(input logic vc, input int n);
        logic [FW-1:0] f;
        for (int i = 0; i < n; i++) begin
            if (i == 0)          f = mk(2'b00, (n == 1) ? 8'd0 : 8'(n - 1), 24'($urandom));
            else if (i == n - 1) f = mk(2'b10, 8'd0, 24'($urandom));
            else                 f = mk(2'b01, 8'd0, 24'($urandom));
            if (vc) src_q1.push_back(f); else src_q0.push_back(f);
        end
    endtask

    task automatic drive_inputs;
        vc_valid[0]        = (src_q0.size() != 0);
        vc_valid[1]        = (src_q1.size() != 0);
        vc_fdata[FW-1:0]   = (src_q0.size() != 0) ? src_q0[0] : '0;
        vc_fdata[2*FW-1:FW] = (src_q1.size() != 0) ? src_q1[0] : '0;
        ready              = rdy;
    endtask

    // One clock: drive at the falling edge, check just before the rising edge.
    task automatic step;
        logic          acc, gv, g;
        logic [NV-1:0] exp_rdy;
        logic [FW-1:0] flit;
        logic [SW-1:0] exp_out;
        logic [1:0]    t;
        logic [PW-1:0] s;
        drive_inputs();
        #3;
        acc = !m_valid || rdy;
        gv  = 1'b0;
        g   = 1'b0;
        if (!m_lock) begin
            if (src_q1.size() != 0)      begin gv = 1'b1; g = 1'b1; end
            else if (src_q0.size() != 0) begin gv = 1'b1; g = 1'b0; end
        end else begin
            g  = m_l;
            gv = m_l ? (src_q1.size() != 0) : (src_q0.size() != 0);
        end
        exp_rdy = (acc && gv) ? (g ? 2'b10 : 2'b01) : 2'b00;
        n_checks++;
        if (vc_ready !== exp_rdy) begin
            n_fail++; $display("FAIL vc_ready: got %b expected %b at %0t", vc_ready, exp_rdy, $time);
        end
        n_checks++;
        if (valid !== m_valid) begin
            n_fail++; $display("FAIL valid: got %b expected %b at %0t", valid, m_valid, $time);
        end
        n_checks++;
        if (lock !== m_lock || dbg_state !== m_lock) begin
            n_fail++; $display("FAIL lock: got %b/%b expected %b at %0t", lock, dbg_state, m_lock, $time);
        end
        n_checks++;
        if (err !== m_err) begin
            n_fail++; $display("FAIL err: got %b expected %b at %0t", err, m_err, $time);
        end
        if (m_valid && rdy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL scoreboard: unexpected flit %h vc %0d at %0t", fdata, vc_id, $time);
            end else begin
                exp_out = exp_q.pop_front();
                if ({vc_id, fdata} !== exp_out) begin
                    n_fail++; $display("FAIL out_flit: got %h expected %h at %0t", {vc_id, fdata}, exp_out, $time);
                end
            end
        end
        m_err = 1'b0;
        if (acc && gv) begin
            flit = g ? src_q1.pop_front() : src_q0.pop_front();
            exp_q.push_back({g, flit});
            m_valid = 1'b1;
            t = flit[FW-1 -: 2];
            s = flit[FW-3 -: PW];
            if (!m_lock) begin
                if (t == 2'b00) begin
                    if (s != 0) begin m_lock = 1'b1; m_l = g; end
                end else m_err = 1'b1;
            end else begin
                if (t == 2'b00) begin
                    m_err = 1'b1;
                    if (s == 0) m_lock = 1'b0;
                end else if (t == 2'b10) m_lock = 1'b0;
                else if (t == 2'b11) m_err = 1'b1;
            end
        end else if (acc) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain;
        bit done = 0;
        rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (src_q0.size() == 0 && src_q1.size() == 0 && exp_q.size() == 0 && !m_valid) begin
                done = 1;
                break;
            end
            step();
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL drain_timeout: pending %0d expected %0d at %0t", exp_q.size(), 0, $time);
        end
    endtask

    task automatic test_reset;
        arst_n   = 1'b0;
        vc_valid = 2'b11;
        vc_fdata = {2{mk(2'b00, 8'd3, 24'hABCDEF)}};
        ready    = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || lock !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b%b%b expected 000", valid, lock, err);
        end
        n_checks++;
        if (fdata !== '0 || vc_id !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: got %h/%0d expected 0/0", fdata, vc_id);
        end
        n_checks++;
        if (vc_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_vc_ready: got %b expected 00", vc_ready);
        end
        arst_n = 1'b1;
        m_valid = 0; m_lock = 0; m_l = 0; m_err = 0;
        drive_inputs();
    endtask

    task automatic test_single;
        src_q0.push_back(mk(2'b00, 8'd0, 24'h000001));
        drain();
    endtask

    task automatic test_priority;
        src_q0.push_back(mk(2'b00, 8'd0, 24'h000010));
        src_q1.push_back(mk(2'b00, 8'd0, 24'h000011));
        drain();
    endtask

    task automatic test_wormhole;
        push_pkt(1'b0, 4);
        rdy = 1'b1;
        step();
        src_q1.push_back(mk(2'b00, 8'd0, 24'h000022));
        drain();
    endtask

    task automatic test_stall;
        logic [FW-1:0] held;
        logic          held_id;
        push_pkt(1'b0, 3);
        push_pkt(1'b1, 2);
        rdy = 1'b1;
        step();
        step();
        held    = fdata;
        held_id = vc_id;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (fdata !== held || vc_id !== held_id) begin
                n_fail++; $display("FAIL stall_hold: got %h expected %h", fdata, held);
            end
        end
        drain();
    endtask

    task automatic test_err;
        src_q1.push_back(mk(2'b01, 8'd0, 24'h000033));
        drain();
        src_q0.push_back(mk(2'b00, 8'd3, 24'h000040));
        src_q0.push_back(mk(2'b00, 8'd0, 24'h000041));
        drain();
        src_q0.push_back(mk(2'b00, 8'd1, 24'h000050));
        src_q0.push_back(mk(2'b11, 8'd0, 24'h000051));
        src_q0.push_back(mk(2'b10, 8'd0, 24'h000052));
        drain();
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            push_pkt(1'b0, $urandom_range(1, 4));
            push_pkt(1'b1, $urandom_range(1, 4));
        end
        for (int i = 0; i < 200; i++) begin
            if (src_q0.size() == 0 && src_q1.size() == 0) break;
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
    endtask

    task automatic test_reset_mid;
        push_pkt(1'b0, 4);
        rdy = 1'b1;
        step();
        step();
        #1 arst_n = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || lock !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: got valid %b lock %b expected 0 0", valid, lock);
        end
        n_checks++;
        if (vc_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_async_ready: got %b expected 00", vc_ready);
        end
        src_q0.delete();
        src_q1.delete();
        exp_q.delete();
        m_valid = 0; m_lock = 0; m_l = 0; m_err = 0;
        drive_inputs();
        @(negedge clk);
        arst_n = 1'b1;
        src_q1.push_back(mk(2'b00, 8'd0, 24'h000060));
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_wormhole();
        test_stall();
        test_err();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
